// File: rtl/eva_intr_collector.sv
// EVA interrupt collector: edge/level capture, mask,
// timestamped event FIFO with valid/ready drain.
module eva_intr_collector #(
    parameter int                  NUM_INTR   = 32,
    parameter int                  FIFO_DEPTH = 8,
    parameter int                  TS_W       = 64,
    parameter logic [NUM_INTR-1:0] EDGE_MODE  = {NUM_INTR{1'b1}}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_INTR-1:0]           interrupt,
    input  logic [NUM_INTR-1:0]           intr_mask,
    input  logic                          clr_vld,
    input  logic [NUM_INTR-1:0]           clr_vec,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [NUM_INTR-1:0]           evt_vec,
    output logic [TS_W-1:0]               evt_tick,
    output logic [$clog2(FIFO_DEPTH):0]   evt_level,
    output logic [15:0]                   ovf_cnt,
    output logic [NUM_INTR-1:0]           in_service
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [NUM_INTR-1:0] intr_ff;
    logic [NUM_INTR-1:0] trig;
    logic [NUM_INTR-1:0] clr_m;
    logic [TS_W-1:0]     tick;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                any_trig;
    logic                empty;
    logic                full;
    logic                pop;
    logic                push;
    logic                drop;

    logic [NUM_INTR-1:0] vec_mem  [FIFO_DEPTH];
    logic [TS_W-1:0]     tick_mem [FIFO_DEPTH];

    // Edge channels fire on 0->1; level channels fire while high and not yet serviced.
    assign trig = ~intr_mask &
                  ((EDGE_MODE & interrupt & ~intr_ff) |
                   (~EDGE_MODE & interrupt & ~in_service));

    assign any_trig = |trig;
    assign empty    = (evt_level == '0);
    assign full     = (evt_level == LW'(FIFO_DEPTH));
    assign pop      = evt_valid & evt_ready;
    assign push     = any_trig & (~full | pop);
    assign drop     = any_trig & full & ~pop;
    assign clr_m    = {NUM_INTR{clr_vld}} & clr_vec;

    assign evt_valid = ~empty;
    assign evt_vec   = empty ? '0 : vec_mem[rd_ptr];
    assign evt_tick  = empty ? '0 : tick_mem[rd_ptr];

    // Free-running timestamp and previous-line sample for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick    <= '0;
            intr_ff <= '0;
        end else begin
            tick    <= tick + 1'b1;
            intr_ff <= interrupt;
        end
    end

    // Level channels stay in service from acceptance until cleared; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_service <= '0;
        end else begin
            in_service <= (in_service & ~clr_m) |
                          ({NUM_INTR{push}} & trig & ~EDGE_MODE);
        end
    end

    // Event storage; contents are only visible through the head while non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            vec_mem[wr_ptr]  <= trig;
            tick_mem[wr_ptr] <= tick;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                evt_level <= evt_level + 1'b1;
            else if (pop && !push)
                evt_level <= evt_level - 1'b1;
        end
    end

    // Saturating count of events lost to a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (drop && ovf_cnt != 16'hFFFF) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_eva_intr_collector.sv
// Bench for eva_intr_collector: directed table, corner
// sequences and random traffic against a queue model.
module tb_eva_intr_collector;

    localparam int NI = 32;
    localparam int DEPTH = 8;
    localparam int TW = 64;
    localparam logic [NI-1:0] EDGE = 32'hFFFF_FFDF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NI-1:0] interrupt;
    logic [NI-1:0] intr_mask;
    logic          clr_vld;
    logic [NI-1:0] clr_vec;
    logic          evt_valid;
    logic          evt_ready;
    logic [NI-1:0] evt_vec;
    logic [TW-1:0] evt_tick;
    logic [3:0]    evt_level;
    logic [15:0]   ovf_cnt;
    logic [NI-1:0] in_service;

    eva_intr_collector #(
        .NUM_INTR(NI),
        .FIFO_DEPTH(DEPTH),
        .TS_W(TW),
        .EDGE_MODE(EDGE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .interrupt(interrupt),
        .intr_mask(intr_mask),
        .clr_vld(clr_vld),
        .clr_vec(clr_vec),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_vec(evt_vec),
        .evt_tick(evt_tick),
        .evt_level(evt_level),
        .ovf_cnt(ovf_cnt),
        .in_service(in_service)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NI-1:0] vec;
        logic [TW-1:0] tick;
    } ev_t;

    typedef struct {
        logic [NI-1:0] intr;
        logic [NI-1:0] mask;
        logic          clr;
        logic [NI-1:0] cvec;
        logic          rdy;
        logic          ev;
        logic [NI-1:0] vec;
        int            lvl;
        logic [NI-1:0] svc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    ev_t           m_q[$];
    logic [NI-1:0] m_prev;
    logic [NI-1:0] m_svc;
    logic [TW-1:0] m_tick;
    logic [15:0]   m_ovf;
    logic [NI-1:0] em;

    vec_t tbl[13];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic [NI-1:0] i, logic [NI-1:0] m,
                                logic c, logic [NI-1:0] cv, logic r,
                                logic e, logic [NI-1:0] v, int l,
                                logic [NI-1:0] s);
        vec_t t;
        t.intr = i; t.mask = m; t.clr = c; t.cvec = cv; t.rdy = r;
        t.ev = e; t.vec = v; t.lvl = l; t.svc = s;
        return t;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_prev = '0;
        m_svc  = '0;
        m_tick = '0;
        m_ovf  = '0;
    endtask

    // One clock of the specified behaviour, evaluated on pre-edge inputs.
    task automatic model_step();
        logic [NI-1:0] trig;
        bit pop, acc;
        trig = '0;
        for (int i = 0; i < NI; i++) begin
            if (!intr_mask[i]) begin
                if (em[i]) trig[i] = interrupt[i] && !m_prev[i];
                else       trig[i] = interrupt[i] && !m_svc[i];
            end
        end
        pop = evt_ready && (m_q.size() > 0);
        acc = (trig != 0) && (m_q.size() < DEPTH || pop);
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            ev_t e;
            e.vec = trig;
            e.tick = m_tick;
            m_q.push_back(e);
        end else if (trig != 0 && m_ovf != 16'hFFFF) begin
            m_ovf = m_ovf + 16'd1;
        end
        for (int i = 0; i < NI; i++) begin
            if (clr_vld && clr_vec[i]) m_svc[i] = 1'b0;
            if (acc && trig[i] && !em[i]) m_svc[i] = 1'b1;
        end
        m_prev = interrupt;
        m_tick = m_tick + 1;
    endtask

    task automatic cmp_model();
        bit e;
        e = (m_q.size() != 0);
        chk("valid", evt_valid, e);
        chk("vec", evt_vec, e ? m_q[0].vec : '0);
        chk("tick", evt_tick, e ? m_q[0].tick : '0);
        chk("level", evt_level, m_q.size());
        chk("ovf", ovf_cnt, m_ovf);
        chk("in_service", in_service, m_svc);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    task automatic idle_in();
        interrupt = '0;
        intr_mask = '0;
        clr_vld   = 1'b0;
        clr_vec   = '0;
        evt_ready = 1'b0;
    endtask

    logic [TW-1:0] prev_tick;

    initial begin
        em = EDGE;
        idle_in();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", evt_valid, 0);
        chk("rst_vec", evt_vec, 0);
        chk("rst_tick", evt_tick, 0);
        chk("rst_level", evt_level, 0);
        chk("rst_ovf", ovf_cnt, 0);
        chk("rst_svc", in_service, 0);
        rst_n = 1'b1;

        // Edge on ch3 seen at edge 10 with timestamp 9.
        repeat (9) cycle();
        interrupt = 32'h8;
        cycle();
        chk("t1_valid", evt_valid, 1);
        chk("t1_vec", evt_vec, 32'h8);
        chk("t1_tick", evt_tick, 9);
        evt_ready = 1'b1;
        cycle();
        evt_ready = 1'b0;
        cycle();
        chk("t1_no2nd", evt_valid, 0);

        // Directed table: simultaneous edges, level service/clear, masking.
        tbl[0]  = mk(32'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(32'h81, 0, 0, 0, 0, 1, 32'h81, 1, 0);
        tbl[2]  = mk(32'h81, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(32'h20, 0, 0, 0, 0, 1, 32'h20, 1, 32'h20);
        tbl[4]  = mk(32'h20, 0, 0, 0, 0, 1, 32'h20, 1, 32'h20);
        tbl[5]  = mk(32'h20, 0, 0, 0, 1, 0, 0, 0, 32'h20);
        tbl[6]  = mk(32'h20, 0, 1, 32'h20, 0, 0, 0, 0, 0);
        tbl[7]  = mk(32'h20, 0, 0, 0, 0, 1, 32'h20, 1, 32'h20);
        tbl[8]  = mk(32'h00, 0, 0, 0, 1, 0, 0, 0, 32'h20);
        tbl[9]  = mk(32'h00, 0, 1, 32'h20, 0, 0, 0, 0, 0);
        tbl[10] = mk(32'h04, 32'h4, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(32'h04, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(32'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 13; k++) begin
            interrupt = tbl[k].intr;
            intr_mask = tbl[k].mask;
            clr_vld   = tbl[k].clr;
            clr_vec   = tbl[k].cvec;
            evt_ready = tbl[k].rdy;
            cycle();
            chk($sformatf("tbl%0d_valid", k), evt_valid, tbl[k].ev);
            chk($sformatf("tbl%0d_vec", k), evt_vec, tbl[k].vec);
            chk($sformatf("tbl%0d_level", k), evt_level, tbl[k].lvl);
            chk($sformatf("tbl%0d_svc", k), in_service, tbl[k].svc);
        end
        idle_in();

        // Nine ch1 pulses into a stalled FIFO: one drop.
        for (int p = 0; p < 9; p++) begin
            interrupt = 32'h2;
            cycle();
            interrupt = 32'h0;
            cycle();
        end
        chk("t4_level", evt_level, 8);
        chk("t4_ovf", ovf_cnt, 1);

        // Trigger while full with a pop in the same cycle: no drop.
        interrupt = 32'h2;
        evt_ready = 1'b1;
        cycle();
        chk("t5_level", evt_level, 8);
        chk("t5_ovf", ovf_cnt, 1);

        // Drain; timestamps must ascend.
        interrupt = 32'h0;
        prev_tick = '0;
        for (int d = 0; d < 8; d++) begin
            chk("drain_valid", evt_valid, 1);
            chk("drain_order", evt_tick > prev_tick, 1);
            prev_tick = evt_tick;
            cycle();
        end
        chk("drain_empty", evt_valid, 0);

        // Queue four events, then asynchronous reset flushes them.
        evt_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            interrupt = 32'h2;
            cycle();
            interrupt = 32'h0;
            cycle();
        end
        chk("t6_level_pre", evt_level, 4);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", evt_valid, 0);
        chk("t6_level", evt_level, 0);
        chk("t6_ovf", ovf_cnt, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic with alternating consumer pressure.
        for (int n = 0; n < 3000; n++) begin
            interrupt = $urandom & $urandom;
            intr_mask = $urandom & $urandom & $urandom;
            clr_vld   = ($urandom_range(0, 3) == 0);
            clr_vec   = $urandom;
            if (((n / 300) % 2) == 1)
                evt_ready = ($urandom_range(0, 9) < 2);
            else
                evt_ready = ($urandom_range(0, 9) < 8);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
